// File: rtl/console_pattern_pkg.sv
// rtl/console_pattern_pkg.sv - shared enums and character-range helpers for console_pattern_gen
package console_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROW    = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_SOLID  = 2'd3
  } pattern_mode_t;

  typedef enum logic {
    ST_WAIT_SYNC = 1'b0,
    ST_ACTIVE    = 1'b1
  } pattern_state_t;

  // Number of distinct codepoints emitted (LAST - FIRST + 1, up to 256).
  function automatic logic [8:0] char_range(input logic [7:0] first_char,
                                            input logic [7:0] last_char);
    return {1'b0, last_char} - {1'b0, first_char} + 9'd1;
  endfunction

  // Row-to-row advance in GRID mode; evaluated only at elaboration.
  function automatic logic [7:0] col_step(input int columns, input logic [8:0] range);
    return 8'(columns % int'(range));
  endfunction

  // a + b folded back into [FIRST, LAST]; b must not exceed the range,
  // so one conditional subtract is always enough.
  function automatic logic [7:0] wrap_add(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [7:0] last_char,
                                          input logic [8:0] range);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, last_char}) sum = sum - range;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/console_pattern_gen_if.sv
// rtl/console_pattern_gen_if.sv - scan position in, glyph selection out
interface console_pattern_gen_if #(
  parameter int BIT_WIDTH  = 10,
  parameter int BIT_HEIGHT = 10
);
  logic [1:0]            mode;
  logic [BIT_WIDTH-1:0]  cx;
  logic [BIT_HEIGHT-1:0] cy;
  logic [7:0]            codepoint;
  logic [7:0]            attribute;
  logic                  frame_tick;

  // master: scan source (hdmi side); slave: the pattern generator
  modport master (output mode, cx, cy, input codepoint, attribute, frame_tick);
  modport slave  (input mode, cx, cy, output codepoint, attribute, frame_tick);
endinterface

// File: rtl/pattern_wrap_counter.sv
// rtl/pattern_wrap_counter.sv - modulo-RANGE character register with load and step-by-N
module pattern_wrap_counter
  import console_pattern_pkg::*;
#(
  parameter logic [7:0] FIRST_CHAR = 8'h30,
  parameter logic [7:0] LAST_CHAR  = 8'h7E
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       load_en,
  input  logic [7:0] load_val,
  input  logic       step_en,
  input  logic [7:0] step_val,
  output logic [7:0] next_value
);
  localparam logic [8:0] RANGE = char_range(FIRST_CHAR, LAST_CHAR);

  logic [7:0] value;

  // load wins over step; stepping wraps inside the character range
  always_comb begin
    next_value = value;
    if (load_en)      next_value = load_val;
    else if (step_en) next_value = wrap_add(value, step_val, LAST_CHAR, RANGE);
  end

  // hold the current character
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) value <= FIRST_CHAR;
    else       value <= next_value;
  end
endmodule

// File: rtl/console_pattern_gen.sv
// rtl/console_pattern_gen.sv - text-mode pattern source for console; optional CONSOLE_PATTERN_BLINK_EN
module console_pattern_gen
  import console_pattern_pkg::*;
#(
  parameter int         BIT_WIDTH     = 10,
  parameter int         BIT_HEIGHT    = 10,
  parameter int         GLYPH_W_LOG2  = 3,
  parameter int         GLYPH_H_LOG2  = 4,
  parameter int         COLUMNS       = 80,
  parameter logic [7:0] FIRST_CHAR    = 8'h30,
  parameter logic [7:0] LAST_CHAR     = 8'h7E,
  parameter int         SCROLL_PERIOD = 60
) (
  input logic                  clk_pixel,
  input logic                  reset,
  console_pattern_gen_if.slave bus
);
  localparam logic [8:0] RANGE    = char_range(FIRST_CHAR, LAST_CHAR);
  localparam logic [7:0] COL_STEP = col_step(COLUMNS, RANGE);
  localparam int         FC_W     = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCROLL_PERIOD - 1);

  pattern_state_t state_q, state_d;
  pattern_mode_t  mode_q, mode_eff;

  logic [BIT_WIDTH-1:0]  cx;
  logic [BIT_HEIGHT-1:0] cy;
  logic [FC_W-1:0]       fc_q, fc_eff;
  logic [7:0]            off_q, off_eff, off_applied;
  logic [7:0]            rb_load, rb_step, rb_next, col_next;
  logic [7:0]            codepoint_q, attribute_q, codepoint_d, attribute_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  cx_zero, frame_start, row_start, glyph_start;
  logic                  running, advance, scroll_wrap, blink;
  logic [2:0]            row_idx;
  logic [3:0]            col_idx, attr_low;

  assign cx = bus.cx;
  assign cy = bus.cy;

  assign cx_zero     = (cx == '0);
  assign frame_start = cx_zero && (cy == '0);
  assign row_start   = cx_zero && (cy[GLYPH_H_LOG2-1:0] == '0) && (cy != '0);
  assign glyph_start = (cx[GLYPH_W_LOG2-1:0] == '0) && !cx_zero;

  // The sync cycle is the first frame start and produces real output.
  assign running = (state_q == ST_ACTIVE) || frame_start;
  // The sync frame is frame 0, so only later frame starts advance the count.
  assign advance     = frame_start && (state_q == ST_ACTIVE);
  assign scroll_wrap = advance && (fc_q == FC_LAST);

  // Values in force for this cycle, so frame-start updates reach the output at once.
  assign fc_eff   = !advance ? fc_q : (scroll_wrap ? '0 : fc_q + FC_W'(1));
  assign off_eff  = !scroll_wrap ? off_q
                  : (({1'b0, off_q} + 9'd1 == RANGE) ? 8'd0 : off_q + 8'd1);
  assign mode_eff = frame_start ? pattern_mode_t'(bus.mode) : mode_q;

  assign off_applied = (mode_eff == MODE_SCROLL) ? off_eff : 8'd0;
  assign rb_load     = wrap_add(FIRST_CHAR, off_applied, LAST_CHAR, RANGE);

  // per-mode row advance
  always_comb begin
    rb_step = 8'd1;
    case (mode_eff)
      MODE_GRID:  rb_step = COL_STEP;
      MODE_SOLID: rb_step = 8'd0;
      default:    rb_step = 8'd1;
    endcase
  end

  pattern_wrap_counter #(.FIRST_CHAR(FIRST_CHAR), .LAST_CHAR(LAST_CHAR)) u_row_base (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .load_en    (frame_start),
    .load_val   (rb_load),
    .step_en    (running && row_start),
    .step_val   (rb_step),
    .next_value (rb_next)
  );

  pattern_wrap_counter #(.FIRST_CHAR(FIRST_CHAR), .LAST_CHAR(LAST_CHAR)) u_column (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .load_en    (running && cx_zero),
    .load_val   (rb_next),
    .step_en    (running && (mode_eff == MODE_GRID) && glyph_start),
    .step_val   (8'd1),
    .next_value (col_next)
  );

  assign row_idx  = 3'(cy >> GLYPH_H_LOG2);
  assign col_idx  = 4'(cx >> GLYPH_W_LOG2);
  assign attr_low = (mode_eff == MODE_SOLID) ? 4'(fc_eff) : col_idx;

`ifdef CONSOLE_PATTERN_BLINK_EN
  // Free-running frame count: the wrapping scroll counter never reaches
  // bit floor(log2(P)) for power-of-two periods, so blink uses its own.
  localparam int BLINK_BIT = $clog2(SCROLL_PERIOD + 1) - 1;
  logic [BLINK_BIT:0] blink_q, blink_eff;

  assign blink_eff = advance ? blink_q + (BLINK_BIT + 1)'(1) : blink_q;
  assign blink     = blink_eff[BLINK_BIT];

  // blink frame counter
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_eff;
  end
`else
  assign blink = 1'b0;
`endif

  // sync FSM and output selection; reset values until the first frame start
  always_comb begin
    state_d      = state_q;
    codepoint_d  = FIRST_CHAR;
    attribute_d  = 8'h00;
    frame_tick_d = 1'b0;
    case (state_q)
      ST_WAIT_SYNC: if (frame_start) state_d = ST_ACTIVE;
      ST_ACTIVE:    state_d = ST_ACTIVE;
      default:      state_d = ST_WAIT_SYNC;
    endcase
    if (running) begin
      codepoint_d  = col_next;
      attribute_d  = {blink, row_idx, attr_low};
      frame_tick_d = frame_start;
    end
  end

  // state, shadow mode, scroll bookkeeping and registered outputs
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_SYNC;
      mode_q       <= MODE_ROW;
      fc_q         <= '0;
      off_q        <= 8'd0;
      codepoint_q  <= FIRST_CHAR;
      attribute_q  <= 8'h00;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_eff;
      fc_q         <= fc_eff;
      off_q        <= off_eff;
      codepoint_q  <= codepoint_d;
      attribute_q  <= attribute_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.codepoint  = codepoint_q;
  assign bus.attribute  = attribute_q;
  assign bus.frame_tick = frame_tick_q;
endmodule

// File: doc/console_pattern_gen.md
# console_pattern_gen

Parametrised text-mode pattern source that drives the `console` glyph renderer's `codepoint` and `attribute` inputs from the HDMI `cx`/`cy` scan position. It generalises the per-row incrementing character demo. Generalisations:
- configurable glyph geometry, character range and column count;
- four run-time selectable pattern modes;
- frame-synchronous scrolling and mode switching.

It sits between `hdmi` (the `cx`/`cy` source) and `console` in board top levels.

## Interface
- `BIT_WIDTH`, 10, width of `cx`.
- `BIT_HEIGHT`, 10, width of `cy`.
- `GLYPH_W_LOG2`, 3, log2 of glyph width in pixels.
- `GLYPH_H_LOG2`, 4, log2 of glyph height in pixels.
- `COLUMNS`, 80, glyph columns per line. Used for GRID row stride.
- `FIRST_CHAR`, 8'h30, lowest emitted codepoint.
- `LAST_CHAR`, 8'h7E, highest emitted codepoint. Must be ≥ `FIRST_CHAR`. RANGE = LAST−FIRST+1.
- `SCROLL_PERIOD`, 60, frames per scroll step. Must be ≥ 1.
- `clk_pixel`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `mode`  in  2  pattern select: 0 ROW, 1 GRID, 2 SCROLL, 3 SOLID.
- `cx`  in  `BIT_WIDTH`  current pixel column.
- `cy`  in  `BIT_HEIGHT`  current pixel row.
- `codepoint`  out  8  character to `console`.
- `attribute`  out  8  attribute to `console`.
- `frame_tick`  out  1  one-cycle pulse at frame start.

## Operation
- FSM `WAIT_SYNC` → `ACTIVE`:
  - Reset enters `WAIT_SYNC`.
  - `WAIT_SYNC` → `ACTIVE` on the first cycle with cx==0 && cy==0.
  - There is no exit from `ACTIVE` except reset.
- In `WAIT_SYNC`, outputs hold their reset values: codepoint=`FIRST_CHAR`, attribute=0, frame_tick=0.
- Frame start is cx==0 && cy==0 in `ACTIVE`, including the sync cycle itself. At frame start:
  - frame_tick pulses.
  - `mode` is latched into a shadow register. Mid-frame mode changes are ignored until the next frame start.
  - row_base reloads to `FIRST_CHAR` + scroll_offset.
- Row start is cx==0 with cy[GLYPH_H_LOG2-1:0]==0 and cy≠0. row_base advances by:
  - ROW/SCROLL: 1.
  - GRID: COL_STEP = COLUMNS mod RANGE.
  - SOLID: 0.
- Column counter behaviour:
  - Reloads from row_base at cx==0.
  - GRID only: steps by 1 when cx[GLYPH_W_LOG2-1:0]==0 and cx≠0.
  - Other modes: column value equals row_base.
- All character arithmetic is modulo RANGE inside [FIRST_CHAR, LAST_CHAR]. Each add is followed by a single conditional subtract of RANGE, with 9-bit intermediates. No multipliers.
- Scroll behaviour:
  - A frame counter counts 0..SCROLL_PERIOD−1 and wraps.
  - On wrap, scroll_offset increments modulo RANGE.
  - scroll_offset is applied only in SCROLL mode. It is zero in the other modes but keeps counting.
- attribute = {blink, row_idx[2:0], col_idx[3:0]}:
  - row_idx is cy>>GLYPH_H_LOG2.
  - col_idx is cx>>GLYPH_W_LOG2.
  - In SOLID mode, col_idx[3:0] is replaced by frame_count[3:0].
- Blanking-region cx/cy values are processed normally. Values produced there are don't-care for `console`.

## Timing
- codepoint and attribute are registered, with 1-cycle latency: outputs at cycle t+1 correspond to cx/cy at t.
- frame_tick is high in the cycle after frame start is sampled.
- Reset is asynchronous and takes effect immediately:
  - all outputs go to their reset values;
  - scroll_offset=0, frame count=0, shadow mode=ROW.
- Reset mid-frame: outputs stay at reset values until the next cx==0,cy==0. No partial-frame output.
- If row start and frame start coincide (cy==0), frame start takes priority.
- If a scroll step and frame start coincide, the new offset is used for that frame's row_base.

## Configuration
- `CONSOLE_PATTERN_BLINK_EN`:
  - Defined: attribute[7] = frame_count bit selected by ⌊log2(SCROLL_PERIOD)⌋, giving a visible blink.
  - Undefined: attribute[7] is constant 0 and the blink logic is absent.

## Structure
- Package `console_pattern_pkg` holds:
  - `pattern_mode_t` enum (ROW, GRID, SCROLL, SOLID);
  - `pattern_state_t` enum (WAIT_SYNC, ACTIVE);
  - a function computing RANGE/COL_STEP.
- Sub-module `pattern_wrap_counter`: modulo-RANGE character register with load, step-by-N and conditional-subtract wrap. It is instantiated for row_base and the column counter.

## Test plan
- ROW, defaults, after sync:
  - cy=0 → codepoint 0x30;
  - cy=16 → 0x31;
  - cy=32 → 0x32;
  - row 79 (cy=1264, with BIT_HEIGHT widened) → wraps to 0x30.
- GRID:
  - cy=0: cx=0 → 0x30, cx=8 → 0x31, cx=16 → 0x32;
  - cy=16, cx=0 → 0x31 (COL_STEP=1).
- SCROLL with SCROLL_PERIOD=2: frames 0–1 give 0x30 at cy=0; frame 2 gives 0x31; offset wraps after 79 steps.
- Mode 0→1 set at cy=100: GRID output begins only after the next cx=0,cy=0. frame_tick is 1 cycle wide, once per frame.
- Reset at cy=200 mid-frame: codepoint=0x30, attribute=0x00, frame_tick=0 until the next cx=0,cy=0. Outputs are then correct with 1-cycle latency.
- Blink: with `CONSOLE_PATTERN_BLINK_EN` and SCROLL_PERIOD=2, attribute[7] toggles every 2 frames. Without the macro it stays 0.
